// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the memory-request arbiter.
//            Holds the arbiter FSM state encoding, the arbitration-mode
//            selectors and the search-order helper used by rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Arbitration mode selectors
    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // Channel examined in search slot k. Round-robin starts one past the
    // previous winner and wraps; fixed priority always scans from index 0.
    // last is always < n, so two conditional subtractions cover the wrap
    // without needing a divider.
    function automatic int rr_slot(input int last, input int k,
                                   input int n, input int mode);
        int v_idx;
        if (mode == PRIO_FIXED) begin
            v_idx = k;
        end else begin
            v_idx = last + 1 + k;
            if (v_idx >= n) v_idx = v_idx - n;
            if (v_idx >= n) v_idx = v_idx - n;
        end
        return v_idx;
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational one-hot winner select. Round-robin mode searches
//            from the channel after i_last; fixed mode picks the lowest
//            requesting index and ignores i_last.
// Ports    : i_req       - request vector (already qualified by caller)
//            i_last      - index of the previous winner
//            o_valid     - at least one request present
//            o_grant     - one-hot winner
//            o_grant_idx - binary index of the winner
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int PRIORITY_MODE = PRIO_RR,
    localparam int IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_last,
    output logic              o_valid,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IDX_W-1:0]  o_grant_idx
);

    always_comb begin : p_select
        int w_idx;
        w_idx       = 0;
        o_valid     = 1'b0;
        o_grant     = '0;
        o_grant_idx = '0;
        // First requester in search order wins; later hits are masked by o_valid.
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = rr_slot(int'(i_last), k, NUM_CH, PRIORITY_MODE);
            if (!o_valid && i_req[w_idx]) begin
                o_valid      = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx  = IDX_W'(w_idx);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter
// Purpose  : Arbitrates cache-line miss requests from NUM_CH cache
//            controllers onto a single AXI master. Each grant optionally
//            performs a dirty-victim write-back, then a line fill, then a
//            one-cycle fill strobe back to the granted channel. A channel
//            may cancel its pending/in-flight fill; the AXI transaction
//            still completes but the strobe is suppressed.
// Ports    : i_clk             - clock
//            i_arst            - asynchronous reset, active low
//            i_req/i_dirty/i_cancel - per-channel request, victim-dirty,
//                                cancel
//            i_read_addr/i_wb_addr/i_wb_data - per-channel packed address
//                                and write-back line (channel c at c*W)
//            i_axi_done/i_axi_data - AXI completion pulse and read line
//            o_axi_addr/o_axi_data - transaction address / write-back line
//            o_axi_write_start/o_axi_read_start - phase levels
//            o_grant           - one-hot granted channel (0 when idle)
//            o_fill_we/o_fill_data - fill strobe and registered fill line
//            o_busy            - arbiter not idle
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int ADDR_WIDTH    = 64,
    parameter int BLOCK_WIDTH   = 512,
    parameter int PRIORITY_MODE = PRIO_RR
) (
    input  logic                          i_clk,
    input  logic                          i_arst,
    input  logic [NUM_CH-1:0]             i_req,
    input  logic [NUM_CH-1:0]             i_dirty,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]  i_read_addr,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]  i_wb_addr,
    input  logic [NUM_CH*BLOCK_WIDTH-1:0] i_wb_data,
    input  logic [NUM_CH-1:0]             i_cancel,
    input  logic                          i_axi_done,
    input  logic [BLOCK_WIDTH-1:0]        i_axi_data,
    output logic [ADDR_WIDTH-1:0]         o_axi_addr,
    output logic [BLOCK_WIDTH-1:0]        o_axi_data,
    output logic                          o_axi_write_start,
    output logic                          o_axi_read_start,
    output logic [NUM_CH-1:0]             o_grant,
    output logic [NUM_CH-1:0]             o_fill_we,
    output logic [BLOCK_WIDTH-1:0]        o_fill_data,
    output logic                          o_busy
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // Pointer starts at the last channel so channel 0 wins the first search.
    localparam logic [IDX_W-1:0] c_last_init = IDX_W'(NUM_CH - 1);

    // ------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------
    arb_state_t              r_state;
    arb_state_t              w_next_state;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_next_idx;
    logic [IDX_W-1:0]        r_last;
    logic [IDX_W-1:0]        w_next_last;
    logic [NUM_CH-1:0]       r_grant;
    logic [NUM_CH-1:0]       w_next_grant;
    logic                    r_cancel;
    logic                    w_next_cancel;
    logic [ADDR_WIDTH-1:0]   r_axi_addr;
    logic [ADDR_WIDTH-1:0]   w_next_addr;
    logic [BLOCK_WIDTH-1:0]  r_axi_data;
    logic [BLOCK_WIDTH-1:0]  w_next_data;
    logic [BLOCK_WIDTH-1:0]  r_fill_data;
    logic [BLOCK_WIDTH-1:0]  w_next_fill_data;

    logic [NUM_CH-1:0]       w_eligible;
    logic                    w_win_valid;
    logic [NUM_CH-1:0]       w_win_grant;
    logic [IDX_W-1:0]        w_win_idx;
    logic                    w_cancel_now;

    // Per-channel views of the packed buses
    logic [ADDR_WIDTH-1:0]   w_rd_addr [NUM_CH];
    logic [ADDR_WIDTH-1:0]   w_wb_addr [NUM_CH];
    logic [BLOCK_WIDTH-1:0]  w_wb_data [NUM_CH];

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
            assign w_rd_addr[c] = i_read_addr[c*ADDR_WIDTH  +: ADDR_WIDTH];
            assign w_wb_addr[c] = i_wb_addr  [c*ADDR_WIDTH  +: ADDR_WIDTH];
            assign w_wb_data[c] = i_wb_data  [c*BLOCK_WIDTH +: BLOCK_WIDTH];
        end
    endgenerate

    // A channel that requests and cancels in the same idle cycle sits out.
    assign w_eligible   = i_req & ~i_cancel;
    assign w_cancel_now = i_cancel[r_idx];

    rr_arbiter #(
        .NUM_CH        (NUM_CH),
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_rr_arbiter (
        .i_req       (w_eligible),
        .i_last      (r_last),
        .o_valid     (w_win_valid),
        .o_grant     (w_win_grant),
        .o_grant_idx (w_win_idx)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-register decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state     = r_state;
        w_next_idx       = r_idx;
        w_next_last      = r_last;
        w_next_grant     = r_grant;
        w_next_cancel    = r_cancel;
        w_next_fill_data = r_fill_data;
        w_next_addr      = '0;
        w_next_data      = '0;

        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_next_idx    = w_win_idx;
                    w_next_last   = w_win_idx;
                    w_next_grant  = w_win_grant;
                    w_next_cancel = 1'b0;
                    w_next_state  = i_dirty[w_win_idx] ? WRITE : READ;
                end
            end
            WRITE: begin
                // A cancelled write-back still proceeds to the read so the
                // AXI side sees a complete write-then-read pair.
                w_next_cancel = r_cancel | w_cancel_now;
                if (i_axi_done) begin
                    w_next_state = READ;
                end
            end
            READ: begin
                // Include a cancel arriving on the completion cycle itself.
                w_next_cancel = r_cancel | w_cancel_now;
                if (i_axi_done) begin
                    w_next_fill_data = i_axi_data;
                    if (w_next_cancel) begin
                        w_next_state = IDLE;
                        w_next_grant = '0;
                    end else begin
                        w_next_state = RESP;
                    end
                end
            end
            RESP: begin
                w_next_state = IDLE;
                w_next_grant = '0;
            end
            default: begin
                w_next_state = IDLE;
                w_next_grant = '0;
            end
        endcase

        // Address/data registers track the phase being entered so they are
        // valid in the same cycle the start level rises.
        if (w_next_state == WRITE) begin
            w_next_addr = w_wb_addr[w_next_idx];
            w_next_data = w_wb_data[w_next_idx];
        end else if (w_next_state == READ) begin
            w_next_addr = w_rd_addr[w_next_idx];
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            r_idx       <= '0;
            r_last      <= c_last_init;
            r_grant     <= '0;
            r_cancel    <= 1'b0;
            r_axi_addr  <= '0;
            r_axi_data  <= '0;
            r_fill_data <= '0;
        end else begin
            r_idx       <= w_next_idx;
            r_last      <= w_next_last;
            r_grant     <= w_next_grant;
            r_cancel    <= w_next_cancel;
            r_axi_addr  <= w_next_addr;
            r_axi_data  <= w_next_data;
            r_fill_data <= w_next_fill_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registers only
    // ------------------------------------------------------------------
    assign o_axi_addr        = r_axi_addr;
    assign o_axi_data        = r_axi_data;
    assign o_axi_write_start = (r_state == WRITE);
    assign o_axi_read_start  = (r_state == READ);
    assign o_grant           = r_grant;
    assign o_fill_we         = (r_state == RESP) ? r_grant : '0;
    assign o_fill_data       = r_fill_data;
    assign o_busy            = (r_state != IDLE);

endmodule : mem_req_arbiter
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_arbiter
// Purpose  : Scoreboard bench for mem_req_arbiter. Two instances, four
//            channels each: round-robin (dut) and fixed priority (dut_fp).
//            Stimulus pushes expected transactions and fills; monitors pop
//            and compare whenever the DUT starts a transaction or strobes
//            a fill.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 64;
    localparam int BW  = 64;

    typedef struct {
        logic [NCH-1:0] grant;
        logic           wr;
        logic [AW-1:0]  wb_a;
        logic [BW-1:0]  wb_d;
        logic [AW-1:0]  rd_a;
    } txn_t;

    typedef struct {
        logic [NCH-1:0] we;
        logic [BW-1:0]  data;
    } fill_t;

    logic              clk;
    logic              arst_n;
    logic [NCH-1:0]    req, dirty, cancel;
    logic [NCH*AW-1:0] rd_addr, wb_addr;
    logic [NCH*BW-1:0] wb_data;
    logic              done;
    logic [BW-1:0]     rdata;
    logic [AW-1:0]     addr;
    logic [BW-1:0]     odata, fill_data;
    logic              ws, rs, busy;
    logic [NCH-1:0]    grant, fill_we;

    logic [NCH-1:0]    fp_req;
    logic [NCH-1:0]    fp_zero;
    logic              fp_done;
    logic [BW-1:0]     fp_rdata;
    logic [AW-1:0]     fp_addr;
    logic [BW-1:0]     fp_odata, fp_fill_data;
    logic              fp_ws, fp_rs, fp_busy;
    logic [NCH-1:0]    fp_grant, fp_fill_we;

    int n_checks = 0;
    int n_pass   = 0;
    int axi_lat  = 0;
    int fp_keep0 = 0;
    bit spur_idle = 0;
    bit spur_resp = 0;

    txn_t           txq[$];
    fill_t          fq[$];
    logic [NCH-1:0] fp_gq[$];
    fill_t          fp_fq[$];

    mem_req_arbiter #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .PRIORITY_MODE(0)) dut (
        .i_clk(clk), .i_arst(arst_n), .i_req(req), .i_dirty(dirty),
        .i_read_addr(rd_addr), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .i_cancel(cancel), .i_axi_done(done), .i_axi_data(rdata),
        .o_axi_addr(addr), .o_axi_data(odata), .o_axi_write_start(ws),
        .o_axi_read_start(rs), .o_grant(grant), .o_fill_we(fill_we),
        .o_fill_data(fill_data), .o_busy(busy));

    mem_req_arbiter #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .PRIORITY_MODE(1)) dut_fp (
        .i_clk(clk), .i_arst(arst_n), .i_req(fp_req), .i_dirty(fp_zero),
        .i_read_addr(rd_addr), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .i_cancel(fp_zero), .i_axi_done(fp_done), .i_axi_data(fp_rdata),
        .o_axi_addr(fp_addr), .o_axi_data(fp_odata), .o_axi_write_start(fp_ws),
        .o_axi_read_start(fp_rs), .o_grant(fp_grant), .o_fill_we(fp_fill_we),
        .o_fill_data(fp_fill_data), .o_busy(fp_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model for read responses
    function automatic logic [BW-1:0] mem_rd(input logic [AW-1:0] a);
        return {a[31:0], 32'hA5A5_A5A5};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // One cycle; requesters drop i_req after their fill strobe
    task automatic tick();
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            if (fill_we[c]) req[c] = 1'b0;
            if (fp_fill_we[c]) begin
                if (c == 0 && fp_keep0 > 0) fp_keep0--;
                else fp_req[c] = 1'b0;
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  64'(busy),      64'd0);
        chk({tag, "_grant"}, 64'(grant),     64'd0);
        chk({tag, "_ws"},    64'(ws),        64'd0);
        chk({tag, "_rs"},    64'(rs),        64'd0);
        chk({tag, "_addr"},  addr,           64'd0);
        chk({tag, "_data"},  odata,          64'd0);
        chk({tag, "_we"},    64'(fill_we),   64'd0);
        chk({tag, "_fdata"}, fill_data,      64'd0);
    endtask

    task automatic wait_level(input string nm, input bit want_write);
        int n = 0;
        while (!(want_write ? ws : rs) && n < 50) begin tick(); n++; end
        chk(nm, 64'(want_write ? ws : rs), 64'd1);
    endtask

    task automatic wait_quiet(input string nm);
        int n = 0;
        while (!(req == 0 && fp_req == 0 && !busy && !fp_busy) && n < 400) begin tick(); n++; end
        chk(nm, 64'(req == 0 && fp_req == 0 && !busy && !fp_busy), 64'd1);
    endtask

    task automatic push_rd(input logic [NCH-1:0] g, input logic [AW-1:0] ra, input logic [BW-1:0] fd, input bit fill);
        txn_t t;
        fill_t f;
        t.grant = g; t.wr = 1'b0; t.wb_a = '0; t.wb_d = '0; t.rd_a = ra;
        txq.push_back(t);
        if (fill) begin f.we = g; f.data = fd; fq.push_back(f); end
    endtask

    // AXI responder for the round-robin instance
    initial begin
        int cnt = 0;
        done = 1'b0;
        rdata = '0;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (spur_idle && !busy) begin
                done = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF; spur_idle = 0;
            end else if (spur_resp && |fill_we) begin
                done = 1'b1; rdata = 64'hDEAD_DEAD_DEAD_DEAD;
            end else if (ws || rs) begin
                if (cnt >= axi_lat) begin
                    done = 1'b1; rdata = rs ? mem_rd(addr) : '0; cnt = 0;
                end else cnt++;
            end else cnt = 0;
        end
    end

    // AXI responder for the fixed-priority instance (single-cycle reads)
    initial begin
        fp_done = 1'b0;
        fp_rdata = '0;
        forever begin
            @(negedge clk);
            fp_done = 1'b0;
            if (fp_rs) begin fp_done = 1'b1; fp_rdata = mem_rd(fp_addr); end
        end
    end

    // Monitor: round-robin instance
    initial begin
        bit   prev_busy = 0;
        bit   prev_ws = 0;
        txn_t cur;
        fill_t f;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            if (!arst_n) begin prev_busy = 0; prev_ws = 0; continue; end
            if (busy && !prev_busy) begin
                if (txq.size() == 0) chk("unexpected_txn", 64'd1, 64'd0);
                else begin
                    cur = txq.pop_front();
                    chk("txn_grant", 64'(grant), 64'(cur.grant));
                    if (cur.wr) begin
                        chk("wb_start", 64'(ws), 64'd1);
                        chk("wb_addr", addr, cur.wb_a);
                        chk("wb_data", odata, cur.wb_d);
                    end else begin
                        chk("rd_start", 64'(rs), 64'd1);
                        chk("rd_addr", addr, cur.rd_a);
                    end
                end
            end
            if (rs && prev_ws) begin
                chk("rd_addr_after_wb", addr, cur.rd_a);
                chk("rd_data_zero", odata, 64'd0);
            end
            if (|fill_we) begin
                if (fq.size() == 0) chk("unexpected_fill", 64'(fill_we), 64'd0);
                else begin
                    f = fq.pop_front();
                    chk("fill_we", 64'(fill_we), 64'(f.we));
                    chk("fill_data", fill_data, f.data);
                end
            end
            prev_busy = busy;
            prev_ws = ws;
        end
    end

    // Monitor: fixed-priority instance
    initial begin
        bit    prev_busy = 0;
        logic [NCH-1:0] g;
        fill_t f;
        forever begin
            @(negedge clk);
            if (!arst_n) begin prev_busy = 0; continue; end
            if (fp_busy && !prev_busy) begin
                if (fp_gq.size() == 0) chk("fp_unexpected_txn", 64'd1, 64'd0);
                else begin g = fp_gq.pop_front(); chk("fp_grant", 64'(fp_grant), 64'(g)); end
            end
            if (|fp_fill_we) begin
                if (fp_fq.size() == 0) chk("fp_unexpected_fill", 64'(fp_fill_we), 64'd0);
                else begin
                    f = fp_fq.pop_front();
                    chk("fp_fill_we", 64'(fp_fill_we), 64'(f.we));
                    chk("fp_fill_data", fp_fill_data, f.data);
                end
            end
            prev_busy = fp_busy;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        #2 arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    // Stimulus
    initial begin
        txn_t  t;
        fill_t f;
        arst_n = 1'b0;
        req = '0; dirty = '0; cancel = '0; fp_req = '0; fp_zero = '0;
        rd_addr = '0; wb_addr = '0; wb_data = '0;
        rd_addr[0*AW +: AW] = 64'h1000;
        rd_addr[1*AW +: AW] = 64'h3000;
        rd_addr[2*AW +: AW] = 64'h4000;
        rd_addr[3*AW +: AW] = 64'h6000;
        wb_addr[1*AW +: AW] = 64'h2000;
        wb_data[1*BW +: BW] = 64'h5A5A_5A5A_5A5A_5A5A;
        wb_addr[3*AW +: AW] = 64'h5000;
        wb_data[3*BW +: BW] = 64'h1234_5678_9ABC_DEF0;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        arst_n = 1'b1;

        // Spurious completion while idle
        spur_idle = 1;
        repeat (3) tick();
        chk("spur_idle_busy", 64'(busy), 64'd0);
        chk("spur_idle_fdata", fill_data, 64'd0);

        // Request and cancel together in idle: not eligible
        push_rd(4'b0001, 64'h1000, 64'h0000_1000_A5A5_A5A5, 1);
        axi_lat = 1;
        req[0] = 1'b1; cancel[0] = 1'b1;
        tick(); tick();
        chk("req_cancel_idle_busy", 64'(busy), 64'd0);
        cancel[0] = 1'b0;
        wait_quiet("clean_read_ch0");

        // Dirty fill on ch1, with a spurious completion during RESP
        t.grant = 4'b0010; t.wr = 1'b1; t.wb_a = 64'h2000;
        t.wb_d = 64'h5A5A_5A5A_5A5A_5A5A; t.rd_a = 64'h3000;
        txq.push_back(t);
        f.we = 4'b0010; f.data = 64'h0000_3000_A5A5_A5A5; fq.push_back(f);
        dirty[1] = 1'b1; req[1] = 1'b1; spur_resp = 1;
        begin
            int n = 0;
            while (fill_we == 0 && n < 50) begin tick(); n++; end
        end
        tick();
        chk("spur_resp_busy", 64'(busy), 64'd0);
        chk("spur_resp_we", 64'(fill_we), 64'd0);
        chk("spur_resp_fdata", fill_data, 64'h0000_3000_A5A5_A5A5);
        spur_resp = 0; dirty[1] = 1'b0;
        wait_quiet("dirty_fill_ch1");

        // Cancel mid-READ on ch2: read completes, no fill strobe
        push_rd(4'b0100, 64'h4000, '0, 0);
        axi_lat = 3;
        req[2] = 1'b1;
        wait_level("cancel_wait_rs", 0);
        tick();
        cancel[2] = 1'b1; req[2] = 1'b0;
        tick();
        cancel[2] = 1'b0;
        chk("cancel_rs_held", 64'(rs), 64'd1);
        wait_quiet("cancel_quiet");
        chk("cancel_no_fill_left", 64'(fq.size()), 64'd0);

        // Asynchronous reset in the middle of a write-back
        t.grant = 4'b1000; t.wr = 1'b1; t.wb_a = 64'h5000;
        t.wb_d = 64'h1234_5678_9ABC_DEF0; t.rd_a = 64'h6000;
        txq.push_back(t);
        axi_lat = 5;
        dirty[3] = 1'b1; req[3] = 1'b1;
        wait_level("rst_wait_ws", 1);
        tick();
        #2 arst_n = 1'b0;
        #1 chk_zero("midwrite_reset");
        req[3] = 1'b0; dirty[3] = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        axi_lat = 0;

        // After reset: ch1 alone wins
        push_rd(4'b0010, 64'h3000, 64'h0000_3000_A5A5_A5A5, 1);
        req = 4'b0010;
        wait_quiet("post_reset_ch1");

        // After reset: ch0 and ch1 together, ch0 first
        do_reset();
        push_rd(4'b0001, 64'h1000, 64'h0000_1000_A5A5_A5A5, 1);
        push_rd(4'b0010, 64'h3000, 64'h0000_3000_A5A5_A5A5, 1);
        req = 4'b0011;
        wait_quiet("post_reset_both");

        // Round-robin contention on four channels
        do_reset();
        push_rd(4'b0001, 64'h1000, 64'h0000_1000_A5A5_A5A5, 1);
        push_rd(4'b0010, 64'h3000, 64'h0000_3000_A5A5_A5A5, 1);
        push_rd(4'b0100, 64'h4000, 64'h0000_4000_A5A5_A5A5, 1);
        push_rd(4'b1000, 64'h6000, 64'h0000_6000_A5A5_A5A5, 1);
        req = 4'b1111;
        wait_quiet("rr_contention");

        // Fixed priority: ch0 re-requests twice and keeps winning
        fp_gq.push_back(4'b0001); fp_gq.push_back(4'b0001); fp_gq.push_back(4'b0001);
        fp_gq.push_back(4'b0010); fp_gq.push_back(4'b0100); fp_gq.push_back(4'b1000);
        f.we = 4'b0001; f.data = 64'h0000_1000_A5A5_A5A5;
        fp_fq.push_back(f); fp_fq.push_back(f); fp_fq.push_back(f);
        f.we = 4'b0010; f.data = 64'h0000_3000_A5A5_A5A5; fp_fq.push_back(f);
        f.we = 4'b0100; f.data = 64'h0000_4000_A5A5_A5A5; fp_fq.push_back(f);
        f.we = 4'b1000; f.data = 64'h0000_6000_A5A5_A5A5; fp_fq.push_back(f);
        fp_keep0 = 2;
        fp_req = 4'b1111;
        wait_quiet("fp_contention");

        tick(); tick();
        chk("txns_left",    64'(txq.size()),   64'd0);
        chk("fills_left",   64'(fq.size()),    64'd0);
        chk("fp_txns_left", 64'(fp_gq.size()), 64'd0);
        chk("fp_fills_left", 64'(fp_fq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_req_arbiter
`default_nettype wire

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Parametrised memory-request arbiter between NUM_CH cache controllers and the single AXI master port at the top level. It generalises the current hard-wired icache/dcache start/address muxing. It grants one requester at a time (round-robin or fixed priority) and sequences an optional dirty-line write-back before each line fill. It returns the fill block to the granted channel with a one-cycle write-enable and supports cancellation of an in-flight fill, for example after a branch redirect.

## Interface
Parameters:
- NUM_CH, 2, number of requesting channels (≥2)
- ADDR_WIDTH, 64, AXI address width
- BLOCK_WIDTH, 512, cache line width
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_arst  in  1  asynchronous reset, active-low
- i_req  in  NUM_CH  per-channel miss request; held until that channel's o_fill_we
- i_dirty  in  NUM_CH  per-channel: victim line dirty, write-back required
- i_read_addr  in  NUM_CH*ADDR_WIDTH  fill address, channel c at bits [c*ADDR_WIDTH +: ADDR_WIDTH]
- i_wb_addr  in  NUM_CH*ADDR_WIDTH  write-back address, packed the same way
- i_wb_data  in  NUM_CH*BLOCK_WIDTH  write-back line, packed the same way
- i_cancel  in  NUM_CH  per-channel discard of the pending or in-flight fill
- i_axi_done  in  1  AXI transaction complete (one-cycle pulse)
- i_axi_data  in  BLOCK_WIDTH  read data, valid with i_axi_done in READ
- o_axi_addr  out  ADDR_WIDTH  transaction address
- o_axi_data  out  BLOCK_WIDTH  write-back data
- o_axi_write_start  out  1  level, high throughout WRITE
- o_axi_read_start  out  1  level, high throughout READ
- o_grant  out  NUM_CH  one-hot granted channel, 0 in IDLE
- o_fill_we  out  NUM_CH  one-cycle fill strobe to the granted channel
- o_fill_data  out  BLOCK_WIDTH  registered fill line
- o_busy  out  1  state ≠ IDLE

## Operation
- States:
  - IDLE: an eligible request exists (i_req & ~i_cancel) → pick winner g, latch it, clear the cancel flag. Go to WRITE if i_dirty[g], else READ.
  - WRITE: stay until i_axi_done, then go to READ. A write-back is always followed by a read, even if cancelled.
  - READ: stay until i_axi_done. On i_axi_done, latch i_axi_data into o_fill_data, then go to RESP if not cancelled, else IDLE.
  - RESP: o_fill_we[g]=1 for exactly one cycle, then go to IDLE.
- Arbitration:
  - Round-robin: the search starts at last_grant+1 modulo NUM_CH. last_grant updates only on a grant.
  - Fixed priority: the lowest eligible index wins, and last_grant is ignored.
- Addresses and data:
  - i_dirty, addresses and data are sampled from channel g every cycle while granted. Requesters hold them stable while granted.
  - o_axi_addr = wb_addr[g] in WRITE, read_addr[g] in READ, 0 otherwise.
  - o_axi_data = wb_data[g] in WRITE, 0 otherwise.
- Cancel: i_cancel[g] high in any WRITE/READ cycle sets a sticky cancel flag. The AXI transaction still completes, and o_fill_we is suppressed.
- i_axi_done is ignored in IDLE and RESP.
- All outputs are decoded from registers only. There is no combinational path from inputs to outputs.

## Timing
- Reset (asynchronous, i_arst low): state=IDLE, last_grant=NUM_CH-1 (so channel 0 wins first), cancel flag=0, grant register=0. All outputs are 0 immediately, including mid-transaction. An in-flight AXI transaction is abandoned; the AXI side is reset together with this block.
- Grant latency:
  - i_req sampled in IDLE at edge N → WRITE/READ, start and o_grant visible after edge N.
  - i_axi_done at edge M in READ → RESP after M, with o_fill_we and o_fill_data valid for one cycle → IDLE after M+1.
  - Minimum clean-miss occupancy: 1 (READ, done same cycle) + 1 (RESP) cycles.
- Back-to-back: the IDLE cycle after RESP is mandatory. The served requester drops i_req in that cycle, so it is not re-granted.
- Simultaneous i_req and i_cancel on the same channel in IDLE: the channel is not eligible that cycle.
- Requests arriving while busy wait. Round-robin guarantees each of NUM_CH channels is granted within NUM_CH grants.

## Structure
- mem_arb_pkg: state enum typedef (IDLE, WRITE, READ, RESP) and PRIORITY_MODE constants (PRIO_RR=0, PRIO_FIXED=1).
- Sub-module rr_arbiter: combinational one-hot winner select from the request vector, pointer and mode, parametrised by NUM_CH.
- The top instantiates mem_req_arbiter with NUM_CH=2 (channel 0 = icache, channel 1 = dcache). This replaces the inline o_axi_addr/start muxing.

## Test plan
- Clean read, ch0: i_req=01, i_dirty=0, read_addr0=0x1000 → read_start=1, addr=0x1000, grant=01. Done with data 0xA5… → next cycle fill_we=01, fill_data=0xA5…, then IDLE.
- Dirty fill, ch1: wb_addr1=0x2000, wb_data=0x5A…, read_addr1=0x3000 → WRITE (addr 0x2000, write_start=1) → after done, READ at 0x3000 → fill_we=10.
- Contention, NUM_CH=4, all i_req held, each dropped after its fill:
  - PRIORITY_MODE=0 → grant order 0,1,2,3.
  - PRIORITY_MODE=1 with ch0 re-raising after each fill → ch0 wins every time.
- Cancel in READ: pulse i_cancel[g] mid-READ → read_start held until done, no fill_we, next state IDLE.
- Reset mid-WRITE: assert i_arst low between clock edges → all outputs 0 immediately. After release, the first request from ch1 alone is granted ch1; with both requesting, ch0 wins.
- Spurious i_axi_done in IDLE and RESP → no state change, no fill_we.
